ram_arbiter: RTL

//  Shares the single-port data RAM between the CPU MEM stage (port C) and a debug/program-loader port (port D).

---
 rtl/ram_arbiter_pkg.sv | 27 ++
 rtl/ram_arbiter_sat_counter.sv | 16 +
 rtl/ram_arbiter.sv | 123 ++++++++++++
 3 files changed

// File: rtl/ram_arbiter_pkg.sv
// Shared types for the RAM arbiter: FSM state and port-owner encodings,
// plus the round-robin pick used when the arbiter is idle.
package ram_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_STATE_IDLE  = 2'd0,
    ARB_STATE_ISSUE = 2'd1,
    ARB_STATE_RESP  = 2'd2
  } arb_state_e;

  typedef enum logic {
    ARB_OWNER_CPU = 1'b0,
    ARB_OWNER_DBG = 1'b1
  } arb_owner_e;

  // A lone requester wins; on a tie the port that was not served last wins.
  function automatic arb_owner_e arb_pick(input logic cpu_req, input logic dbg_req,
                                          input arb_owner_e last);
    if (cpu_req && dbg_req)
      return (last == ARB_OWNER_CPU) ? ARB_OWNER_DBG : ARB_OWNER_CPU;
    else if (dbg_req)
      return ARB_OWNER_DBG;
    else
      return ARB_OWNER_CPU;
  endfunction

endpackage

// File: rtl/ram_arbiter_sat_counter.sv
// 32-bit saturating event counter; sticks at all-ones until reset.
module ram_arbiter_sat_counter (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        inc,
  output logic [31:0] count
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      count <= '0;
    else
      count <= (inc && (count != '1)) ? count + 32'd1 : count;
  end

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing the single-port data RAM between the CPU MEM
// stage and the debug port. Perf counters are built only with RAM_ARBITER_PERF_EN.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cpu_req,
  input  logic                  cpu_wren,
  input  logic [ADDR_WIDTH-1:0] cpu_address,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_ack,
  output logic                  cpu_busy,
  input  logic                  dbg_req,
  input  logic                  dbg_wren,
  input  logic [ADDR_WIDTH-1:0] dbg_address,
  input  logic [DATA_WIDTH-1:0] dbg_wdata,
  output logic [DATA_WIDTH-1:0] dbg_rdata,
  output logic                  dbg_ack,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  output logic                  ram_wren,
  input  logic [DATA_WIDTH-1:0] ram_data,
  output logic [31:0]           perf_cpu_wait,
  output logic [31:0]           perf_dbg_cnt
);

  arb_state_e state;
  arb_owner_e owner;
  arb_owner_e last;
  logic       wren_q;
  logic       start;
  arb_owner_e pick;
  logic       pick_dbg;

  // From RESP only the non-owner may start a new access; the owner waits
  // for IDLE so the other port always gets its turn.
  always_comb begin
    start = 1'b0;
    pick  = owner;
    case (state)
      ARB_STATE_IDLE: begin
        start = cpu_req | dbg_req;
        pick  = arb_pick(cpu_req, dbg_req, last);
      end
      ARB_STATE_RESP: begin
        start = (owner == ARB_OWNER_CPU) ? dbg_req : cpu_req;
        pick  = (owner == ARB_OWNER_CPU) ? ARB_OWNER_DBG : ARB_OWNER_CPU;
      end
      default: ;
    endcase
    pick_dbg = (pick == ARB_OWNER_DBG);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ARB_STATE_IDLE;
      owner       <= ARB_OWNER_CPU;
      last        <= ARB_OWNER_DBG;
      wren_q      <= 1'b0;
      ram_address <= '0;
      ram_wdata   <= '0;
      cpu_ack     <= 1'b0;
      dbg_ack     <= 1'b0;
    end else begin
      cpu_ack <= 1'b0;
      dbg_ack <= 1'b0;
      case (state)
        ARB_STATE_ISSUE: begin
          state   <= ARB_STATE_RESP;
          cpu_ack <= (owner == ARB_OWNER_CPU);
          dbg_ack <= (owner == ARB_OWNER_DBG);
        end
        default: begin
          if (start) begin
            state       <= ARB_STATE_ISSUE;
            owner       <= pick;
            last        <= pick;
            ram_address <= pick_dbg ? dbg_address : cpu_address;
            ram_wdata   <= pick_dbg ? dbg_wdata : cpu_wdata;
            wren_q      <= pick_dbg ? dbg_wren : cpu_wren;
          end else begin
            state <= ARB_STATE_IDLE;
          end
        end
      endcase
    end
  end

  // Decoded from state so an asynchronous reset drops the write strobe at once.
  always_comb begin
    ram_wren  = (state == ARB_STATE_ISSUE) & wren_q;
    cpu_rdata = cpu_ack ? ram_data : '0;
    dbg_rdata = dbg_ack ? ram_data : '0;
    cpu_busy  = cpu_req & ~cpu_ack;
  end

`ifdef RAM_ARBITER_PERF_EN
  ram_arbiter_sat_counter u_cpu_wait (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (cpu_busy),
    .count   (perf_cpu_wait)
  );

  ram_arbiter_sat_counter u_dbg_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (dbg_ack),
    .count   (perf_dbg_cnt)
  );
`else
  always_comb begin
    perf_cpu_wait = '0;
    perf_dbg_cnt  = '0;
  end
`endif

endmodule
